ps2_scancode_ctrl: RTL and testbench



---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_event_fifo.sv | 59 +++++
 rtl/ps2_scancode_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ps2_scancode_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code sequencer: FSM state codes,
// Set-2 byte constants and the key event record.
package ps2_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_EXT     = 3'd1;
    localparam state_t ST_BRK     = 3'd2;
    localparam state_t ST_EXT_BRK = 3'd3;
    localparam state_t ST_PAUSE   = 3'd4;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;
    localparam logic [7:0] BAT_OK    = 8'hAA;
    localparam logic [7:0] BAT_FAIL  = 8'hFC;
    localparam logic [7:0] ACK       = 8'hFA;
    localparam logic [7:0] RESEND    = 8'hFE;
    localparam logic [7:0] OVR0      = 8'h00;
    localparam logic [7:0] OVR1      = 8'hFF;

    localparam int         EVENT_W    = 10;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    // Any of the three multi-byte prefix bytes.
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PFX_EXT) || (b == PFX_BRK) || (b == PFX_PAUSE);
    endfunction

    // Keyboard buffer-overrun codes, illegal in any decoding state.
    function automatic logic is_overrun(input logic [7:0] b);
        return (b == OVR0) || (b == OVR1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO holding decoded key events. A push while full is only
// accepted when a pop frees a slot in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed because head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// Set-2 scan-code sequencer: folds E0/F0/E1 prefixes into single key events,
// flags status bytes and protocol errors, and queues events for the consumer.
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [7:0]                  i_byte,
    input  logic                        i_byte_valid,
    output logic [7:0]                  o_key_code,
    output logic                        o_key_ext,
    output logic                        o_key_release,
    output logic                        o_key_valid,
    input  logic                        i_key_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_overflow,
    input  logic                        i_clr_overflow,
    output logic                        o_bat_ok,
    output logic                        o_ack,
    output logic                        o_resend,
    output logic                        o_err
);

    localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_t     state, next_state;
    logic [2:0] skip, next_skip;
    logic [TW-1:0] timer;
    logic       timeout;
    logic       push;
    key_event_t push_evt;
    key_event_t head_evt;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       bat_n, ack_n, resend_n, err_n;

    assign pop           = o_key_valid & i_key_ready;
    assign o_key_valid   = ~fifo_empty;
    assign o_key_code    = head_evt.code;
    assign o_key_ext     = head_evt.ext;
    assign o_key_release = head_evt.rel;

    // Byte decoder: next state, event to push and status/error pulse requests.
    always_comb begin
        next_state = state;
        next_skip  = skip;
        push       = 1'b0;
        push_evt   = '0;
        bat_n      = 1'b0;
        ack_n      = 1'b0;
        resend_n   = 1'b0;
        err_n      = 1'b0;
        timeout    = (state != ST_IDLE) && !i_byte_valid && (timer == TMAX);
        if (i_byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (i_byte == PFX_EXT) begin
                        next_state = ST_EXT;
                    end else if (i_byte == PFX_BRK) begin
                        next_state = ST_BRK;
                    end else if (i_byte == PFX_PAUSE) begin
                        next_state = ST_PAUSE;
                        next_skip  = PAUSE_SKIP;
                    end else if (i_byte == BAT_OK) begin
                        bat_n = 1'b1;
                    end else if (i_byte == ACK) begin
                        ack_n = 1'b1;
                    end else if (i_byte == RESEND) begin
                        resend_n = 1'b1;
                    end else if (is_overrun(i_byte) || i_byte == BAT_FAIL) begin
                        err_n = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_evt = {1'b0, 1'b0, i_byte};
                    end
                end
                ST_EXT: begin
                    if (i_byte == PFX_BRK) begin
                        next_state = ST_EXT_BRK;
                    end else if (is_prefix(i_byte) || is_overrun(i_byte)) begin
                        err_n      = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        push       = 1'b1;
                        push_evt   = {1'b1, 1'b0, i_byte};
                        next_state = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    next_state = ST_IDLE;
                    if (is_prefix(i_byte) || is_overrun(i_byte)) begin
                        err_n = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_evt = {(state == ST_EXT_BRK), 1'b1, i_byte};
                    end
                end
                ST_PAUSE: begin
                    next_skip = skip - 3'd1;
                    if (skip == 3'd1) begin
                        push       = 1'b1;
                        push_evt   = {1'b1, 1'b0, PFX_PAUSE};
                        next_state = ST_IDLE;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end else if (timeout) begin
            err_n      = 1'b1;
            next_state = ST_IDLE;
        end
    end

    // State, Pause skip counter and inter-byte timer (idle keeps it at zero).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            skip  <= '0;
            timer <= '0;
        end else begin
            state <= next_state;
            skip  <= next_skip;
            if (i_byte_valid || timeout || state == ST_IDLE) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

    // Registered one-cycle pulses and the sticky overflow flag (set beats clear).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bat_ok   <= 1'b0;
            o_ack      <= 1'b0;
            o_resend   <= 1'b0;
            o_err      <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_bat_ok <= bat_n;
            o_ack    <= ack_n;
            o_resend <= resend_n;
            o_err    <= err_n;
            if (push && fifo_full && !pop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                o_overflow <= 1'b0;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head_evt),
        .count     (o_fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Directed bench for the PS/2 scan-code sequencer.
module tb_ps2_scancode_ctrl;

    localparam int T = 40;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_byte;
    logic       byte_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       clr_overflow;
    logic       bat_ok, ack, resend, err;
    logic [9:0] head;

    int checks = 0;
    int errors = 0;

    assign head = {key_ext, key_release, key_code};

    always #5 clk = ~clk;

    ps2_scancode_ctrl #(
        .TIMEOUT_CYCLES (T),
        .FIFO_DEPTH     (D)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_byte         (in_byte),
        .i_byte_valid   (byte_valid),
        .o_key_code     (key_code),
        .o_key_ext      (key_ext),
        .o_key_release  (key_release),
        .o_key_valid    (key_valid),
        .i_key_ready    (key_ready),
        .o_fifo_count   (fifo_count),
        .o_overflow     (overflow),
        .i_clr_overflow (clr_overflow),
        .o_bat_ok       (bat_ok),
        .o_ack          (ack),
        .o_resend       (resend),
        .o_err          (err)
    );

    // Strobe one byte; returns mid-cycle N+1 where registered results are visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_byte    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Pop the head entry with a one-cycle ready.
    task automatic pop_one();
        @(negedge clk);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({key_valid, fifo_count, overflow} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got valid=%b count=%0d ovf=%b want 0", key_valid, fifo_count, overflow);
        end
        checks++;
        if ({head, bat_ok, ack, resend, err} !== 14'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got head=%h pulses=%b want 0", head, {bat_ok, ack, resend, err});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_make();
        send_byte(8'h1C);
        checks++;
        if (key_valid !== 1'b1 || head !== 10'h01C || fifo_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL make_1C: got valid=%b head=%h count=%0d want 1 01c 1", key_valid, head, fifo_count);
        end
        pop_one();
        checks++;
        if (key_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL make_pop: got valid=%b count=%0d want 0 0", key_valid, fifo_count);
        end
    endtask

    task automatic test_break();
        send_byte(8'hF0);
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL brk_prefix_only: got count=%0d want 0", fifo_count);
        end
        send_byte(8'h1C);
        checks++;
        if (head !== 10'h11C || fifo_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL brk_1C: got head=%h count=%0d want 11c 1", head, fifo_count);
        end
        pop_one();
        send_byte(8'hE0);
        send_byte(8'hF0);
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL ext_brk_prefix_only: got count=%0d want 0", fifo_count);
        end
        send_byte(8'h75);
        checks++;
        if (head !== 10'h375 || fifo_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL ext_brk_75: got head=%h count=%0d want 375 1", head, fifo_count);
        end
        pop_one();
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        int early;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        early = 0;
        for (int i = 0; i < 7; i++) begin
            send_byte(seq[i]);
            if (fifo_count !== 4'd0 || err !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("[TB] FAIL pause_early: got %0d bytes with event/err want 0", early);
        end
        send_byte(seq[7]);
        checks++;
        if (head !== 10'h2E1 || fifo_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL pause_event: got head=%h count=%0d want 2e1 1", head, fifo_count);
        end
        pop_one();
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL pause_single: got count=%0d want 0", fifo_count);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        send_byte(8'hE0);
        for (int off = 1; off <= T + 4; off++) begin
            if (err === 1'b1) begin
                pulses++;
                at = off;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1 || at != T + 1) begin
            errors++;
            $display("[TB] FAIL timeout_err: got %0d pulses at offset %0d want 1 at %0d", pulses, at, T + 1);
        end
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL timeout_no_event: got count=%0d want 0", fifo_count);
        end
        send_byte(8'h1C);
        checks++;
        if (head !== 10'h01C) begin
            errors++;
            $display("[TB] FAIL timeout_recover: got head=%h want 01c", head);
        end
        pop_one();

        pulses = 0;
        send_byte(8'hE0);
        for (int k = 0; k < T - 2; k++) begin
            if (err === 1'b1) pulses++;
            @(negedge clk);
        end
        send_byte(8'h1C);
        for (int k = 0; k < 3; k++) begin
            if (err === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("[TB] FAIL timeout_byte_wins: got %0d err pulses want 0", pulses);
        end
        checks++;
        if (head !== 10'h21C || fifo_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL timeout_byte_event: got head=%h count=%0d want 21c 1", head, fifo_count);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        int bad;
        bad = 0;
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1 || head !== 10'h001) begin
            errors++;
            $display("[TB] FAIL ovf_fill: got count=%0d ovf=%b head=%h want 8 1 001", fifo_count, overflow, head);
        end
        @(negedge clk);
        in_byte    = 8'h0A;
        byte_valid = 1'b1;
        key_ready  = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        key_ready  = 1'b0;
        checks++;
        if (fifo_count !== 4'd8 || head !== 10'h002) begin
            errors++;
            $display("[TB] FAIL ovf_push_pop_full: got count=%0d head=%h want 8 002", fifo_count, head);
        end
        key_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 8'(i + 2) : 8'h0A;
            if (head !== {2'b00, exp}) bad++;
            @(negedge clk);
        end
        key_ready = 1'b0;
        checks++;
        if (bad != 0 || fifo_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL ovf_drain_order: got %0d wrong heads count=%0d want 0 0", bad, fifo_count);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: got %b want 1", overflow);
        end
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [5];
        logic [9:0] exp [3];
        int bad;
        seq = '{8'h1C, 8'hF0, 8'h32, 8'hE0, 8'h75};
        exp = '{10'h01C, 10'h132, 10'h275};
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_byte    = seq[i];
            byte_valid = 1'b1;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (fifo_count !== 4'd3) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d want 3", fifo_count);
        end
        key_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (head !== exp[i]) bad++;
            @(negedge clk);
        end
        key_ready = 1'b0;
        checks++;
        if (bad != 0 || key_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_events: got %0d wrong heads valid=%b want 0 0", bad, key_valid);
        end
    endtask

    task automatic test_status();
        logic [7:0] codes [4];
        logic [3:0] want [4];
        codes = '{8'hAA, 8'hFA, 8'hFE, 8'hFF};
        want  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            send_byte(codes[i]);
            checks++;
            if ({bat_ok, ack, resend, err} !== want[i] || fifo_count !== 4'd0) begin
                errors++;
                $display("[TB] FAIL status_%h: got pulses=%b count=%0d want %b 0", codes[i], {bat_ok, ack, resend, err}, fifo_count, want[i]);
            end
            @(negedge clk);
            checks++;
            if ({bat_ok, ack, resend, err} !== 4'b0) begin
                errors++;
                $display("[TB] FAIL status_%h_width: got pulses=%b want 0000", codes[i], {bat_ok, ack, resend, err});
            end
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h1C);
        send_byte(8'hE0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b0 || fifo_count !== 4'd0 || head !== 10'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_flush: got valid=%b count=%0d head=%h want 0 0 000", key_valid, fifo_count, head);
        end
        rst_n = 1'b1;
        send_byte(8'h1C);
        checks++;
        if (head !== 10'h01C || fifo_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL reset_mid_decode: got head=%h count=%0d want 01c 1", head, fifo_count);
        end
        pop_one();
    endtask

    initial begin
        in_byte      = 8'h00;
        byte_valid   = 1'b0;
        key_ready    = 1'b0;
        clr_overflow = 1'b0;
        test_reset();
        test_make();
        test_break();
        test_pause();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_status();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
